jtkicker_vidmix: RTL
====================

Name: jtkicker_vidmix

Overview:
Parametrised N-layer colour mixer and palette stage for the Kicker-family video tops, the next generation after the fixed two-layer scroll/object mixer. It takes per-layer pixel indices from the scroll and object engines and resolves priority with per-layer enables. It looks up a bank-selected colour LUT, then per-channel RGB PROMs, and outputs delayed blanking plus RGB. Palette bank and flip are shadow-latched at frame boundaries so game writes never tear mid-frame.

Parameters:
NLAYERS, 2, number of pixel layers (2..4); layer 0 has the highest default priority.
PXLW, 4, bits per layer pixel; value 0 means transparent.
PALW, 3, palette bank select width.
COLW, 4, bits per RGB channel.
IDXW, 2, layer index width in the LUT address (at least clog2(NLAYERS)).

Ports:
clk  in  1  video clock, 48 MHz
rst  in  1  synchronous active-high reset
pxl_cen  in  1  pixel clock enable
LHBL  in  1  horizontal blank, active low
LVBL  in  1  vertical blank, active low
pal_sel  in  PALW  palette bank requested by the CPU
flip  in  1  screen flip requested by the CPU
flip_act  out  1  flip value actually applied, sent to the layer engines
prio  in  1  when high, layer 1 outranks layer 0
layer_pxl  in  NLAYERS*PXLW  packed layer pixels; layer i is at [i*PXLW +: PXLW]
gfx_en  in  NLAYERS  per-layer debug enable; 0 forces that layer transparent
prog_addr  in  PALW+IDXW+PXLW  PROM download address
prog_data  in  8  PROM download data
prog_sel  in  2  PROM download target: 0 red, 1 green, 2 blue, 3 LUT
prog_en  in  1  PROM download write strobe
red  out  COLW  red channel
green  out  COLW  green channel
blue  out  COLW  blue channel
LHBL_dly  out  1  LHBL delayed to match the pixel latency
LVBL_dly  out  1  LVBL delayed to match the pixel latency

Behaviour:
- Clocking: single clock domain (clk). Rst is synchronous and active-high. The pixel pipeline advances only on cycles where pxl_cen=1.
- Reset values:
  - red, green, blue, LHBL_dly, LVBL_dly, flip_act: all 0.
  - Shadow pal register: 0.
  - All pipeline stages: cleared to a blanked state.
  - PROM/LUT contents are not cleared by reset.
- Shadow latch:
  - On the pxl_cen cycle where the registered LVBL goes 1 to 0 (start of vblank), pal_sel is copied to pal_lat and flip is copied to flip_act.
  - Changes at any other time have no effect until the next vblank start.
- Stage 1, priority resolution:
  - Effective pixel for layer i is layer_pxl[i] & {PXLW{gfx_en[i]}}.
  - Search order is 0,1,2,...; when prio=1, layers 0 and 1 swap places in that order.
  - The winner is the first layer in the order whose effective pixel is non-zero.
  - If every layer is zero, the winner is layer NLAYERS-1 with pixel 0 (background colour).
  - LUT read address = {pal_lat, win_idx[IDXW-1:0], win_pxl}.
- Stage 2: the 8-bit LUT output addresses three 256-entry RGB PROMs, each COLW bits wide.
- Stage 3: RGB is registered. Output is forced to 0 whenever the delayed blank (LHBL_dly & LVBL_dly) is 0.
- Latency: exactly 3 pxl_cen ticks from layer_pxl/LHBL/LVBL to the outputs. LHBL_dly/LVBL_dly use the same 3-stage shift.
- PROM download:
  - When prog_en=1, the write happens on that clk edge regardless of pxl_cen.
  - prog_sel chooses the memory. RGB PROMs use prog_addr[7:0] and prog_data[COLW-1:0]. The LUT uses the full prog_addr and 8 data bits.
  - A simultaneous pixel read of the same address returns the old data.
- Boundaries:
  - prio is ignored when NLAYERS=1.
  - A vblank start that coincides with a pal_sel change latches the new value.
  - Asserting rst mid-frame blanks the outputs on the next clk edge. Pixels resume 3 pxl_cen ticks after rst is released.

Optional Feature:
- Macro: JTKICKER_VBL_LATCH_EN.
- Defined: shadow latching exactly as described above.
- Undefined: pal_lat and flip_act are re-registered from pal_sel/flip on every pxl_cen, giving one pxl_cen of delay and no frame alignment. This is for games that change the palette mid-screen.

Decomposition:
- Package jtkicker_vidmix_pkg holds:
  - localparams PROG_RED=0, PROG_GRN=1, PROG_BLU=2, PROG_LUT=3;
  - the pipeline depth constant VMIX_DLY=3;
  - a function computing LUT address width.
- One sub-module, jtkicker_vidmix_prio: the combinational ordered priority encoder (effective pixels, gfx_en, prio → win_idx, win_pxl), instantiated once in stage 1.

Test Plan:
- Reset, then NLAYERS=2, layer0=0, layer1=5, prio=0, pal_lat=0, LUT[{0,1,5}]=0x12, R/G/B[0x12]=3/7/9 → after 3 pxl_cen, RGB=3/7/9.
- Layer0=4, layer1=5: prio=0 gives LUT addr {pal,0,4}; prio=1 gives {pal,1,5}. With gfx_en=2'b10 and prio=0, layer1 wins.
- Write pal_sel=5 mid-frame → colours keep using bank 0 until LVBL falls, then bank 5 from the next pixel. With the macro undefined, the bank switches 1 pxl_cen after the write.
- LHBL pulsed low for 10 pxl_cen → LHBL_dly low for exactly 10 pxl_cen, starting 3 ticks later; RGB=0 throughout that window.
- Write PROM red[0x12]=0xA while displaying colour 0x12 → the next read shows 0xA; writes land with pxl_cen held low.
- Assert rst for 1 clk mid-line → RGB, LHBL_dly and flip_act go to 0 on the next clk edge; valid pixels return 3 pxl_cen after rst is released.

Source files
------------

// File: rtl/jtkicker_vidmix_pkg.sv
// ============================================================================
// jtkicker_vidmix_pkg : shared constants for the Kicker video mixer
// Rev 1.0
// ============================================================================
`default_nettype none

package jtkicker_vidmix_pkg;

  localparam logic [1:0] PROG_RED = 2'd0;
  localparam logic [1:0] PROG_GRN = 2'd1;
  localparam logic [1:0] PROG_BLU = 2'd2;
  localparam logic [1:0] PROG_LUT = 2'd3;

  localparam int VMIX_DLY = 3;

  function automatic int lut_aw(input int palw, input int idxw, input int pxlw);
    return palw + idxw + pxlw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtkicker_vidmix_prio.sv
// ============================================================================
// jtkicker_vidmix_prio : combinational layer priority encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module jtkicker_vidmix_prio
  import jtkicker_vidmix_pkg::*;
#(
  parameter int NLAYERS = 2,
  parameter int PXLW    = 4,
  parameter int IDXW    = 2
) (
  input  logic [NLAYERS*PXLW-1:0] layer_pxl,
  input  logic [NLAYERS-1:0]      gfx_en,
  input  logic                    prio,
  output logic [IDXW-1:0]         win_idx,
  output logic [PXLW-1:0]         win_pxl
);

  logic [PXLW-1:0] eff [NLAYERS];
  logic [PXLW-1:0] ord [NLAYERS];
  logic            swap;

  assign swap = prio & (NLAYERS > 1);

  for (genvar i = 0; i < NLAYERS; i++) begin : g_eff
    assign eff[i] = layer_pxl[i*PXLW +: PXLW] & {PXLW{gfx_en[i]}};
  end

  // ord[] holds the layers in search order; only slots 0/1 can be exchanged
  for (genvar i = 0; i < NLAYERS; i++) begin : g_ord
    if (i < 2 && NLAYERS > 1) begin : g_swap
      assign ord[i] = swap ? eff[1-i] : eff[i];
    end else begin : g_keep
      assign ord[i] = eff[i];
    end
  end

  always_comb begin
    win_idx = IDXW'(NLAYERS-1);
    win_pxl = '0;
    for (int k = NLAYERS-1; k >= 0; k--) begin
      if (ord[k] != '0) begin
        win_pxl = ord[k];
        win_idx = (swap && k < 2) ? IDXW'(1-k) : IDXW'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtkicker_vidmix.sv
// ============================================================================
// jtkicker_vidmix : N-layer priority mixer, colour LUT and RGB PROM stage
// Option macro JTKICKER_VBL_LATCH_EN: palette/flip latched at vblank start.
// Rev 1.0
// ============================================================================
`default_nettype none

module jtkicker_vidmix
  import jtkicker_vidmix_pkg::*;
#(
  parameter int NLAYERS = 2,
  parameter int PXLW    = 4,
  parameter int PALW    = 3,
  parameter int COLW    = 4,
  parameter int IDXW    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pxl_cen,
  input  logic                      LHBL,
  input  logic                      LVBL,
  input  logic [PALW-1:0]           pal_sel,
  input  logic                      flip,
  output logic                      flip_act,
  input  logic                      prio,
  input  logic [NLAYERS*PXLW-1:0]   layer_pxl,
  input  logic [NLAYERS-1:0]        gfx_en,
  input  logic [PALW+IDXW+PXLW-1:0] prog_addr,
  input  logic [7:0]                prog_data,
  input  logic [1:0]                prog_sel,
  input  logic                      prog_en,
  output logic [COLW-1:0]           red,
  output logic [COLW-1:0]           green,
  output logic [COLW-1:0]           blue,
  output logic                      LHBL_dly,
  output logic                      LVBL_dly
);

  localparam int LUTAW = lut_aw(PALW, IDXW, PXLW);

  logic [7:0]      lut_mem [2**LUTAW];
  logic [COLW-1:0] red_mem [256];
  logic [COLW-1:0] grn_mem [256];
  logic [COLW-1:0] blu_mem [256];

  logic [IDXW-1:0] win_idx;
  logic [PXLW-1:0] win_pxl;

  logic [PALW-1:0]     pal_lat_q,   pal_lat_d;
  logic                flip_act_q,  flip_act_d;
  logic                lvbl_last_q, lvbl_last_d;
  logic [LUTAW-1:0]    lut_addr_q,  lut_addr_d;
  logic [7:0]          lut_q,       lut_d;
  logic [COLW-1:0]     red_q,       red_d;
  logic [COLW-1:0]     green_q,     green_d;
  logic [COLW-1:0]     blue_q,      blue_d;
  logic [VMIX_DLY-1:0] hbl_sh_q,    hbl_sh_d;
  logic [VMIX_DLY-1:0] vbl_sh_q,    vbl_sh_d;

  jtkicker_vidmix_prio #(
    .NLAYERS (NLAYERS),
    .PXLW    (PXLW),
    .IDXW    (IDXW)
  ) u_prio (
    .layer_pxl (layer_pxl),
    .gfx_en    (gfx_en),
    .prio      (prio),
    .win_idx   (win_idx),
    .win_pxl   (win_pxl)
  );

  always_comb begin
    pal_lat_d   = pal_lat_q;
    flip_act_d  = flip_act_q;
    lvbl_last_d = lvbl_last_q;
    lut_addr_d  = lut_addr_q;
    lut_d       = lut_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    hbl_sh_d    = hbl_sh_q;
    vbl_sh_d    = vbl_sh_q;
    if (pxl_cen) begin
      lvbl_last_d = LVBL;
      hbl_sh_d    = {hbl_sh_q[VMIX_DLY-2:0], LHBL};
      vbl_sh_d    = {vbl_sh_q[VMIX_DLY-2:0], LVBL};
      lut_addr_d  = {pal_lat_q, win_idx, win_pxl};
      lut_d       = lut_mem[lut_addr_q];
      // colour is gated with the blanking that lands in the output stage alongside it
      if (hbl_sh_q[VMIX_DLY-2] & vbl_sh_q[VMIX_DLY-2]) begin
        red_d   = red_mem[lut_q];
        green_d = grn_mem[lut_q];
        blue_d  = blu_mem[lut_q];
      end else begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
      end
`ifdef JTKICKER_VBL_LATCH_EN
      if (lvbl_last_q && !LVBL) begin
        pal_lat_d  = pal_sel;
        flip_act_d = flip;
      end
`else
      pal_lat_d  = pal_sel;
      flip_act_d = flip;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_lat_q   <= '0;
      flip_act_q  <= 1'b0;
      lvbl_last_q <= 1'b0;
      lut_addr_q  <= '0;
      lut_q       <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hbl_sh_q    <= '0;
      vbl_sh_q    <= '0;
    end else begin
      pal_lat_q   <= pal_lat_d;
      flip_act_q  <= flip_act_d;
      lvbl_last_q <= lvbl_last_d;
      lut_addr_q  <= lut_addr_d;
      lut_q       <= lut_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hbl_sh_q    <= hbl_sh_d;
      vbl_sh_q    <= vbl_sh_d;
    end
  end

  // Download port is independent of pxl_cen; same-edge pixel reads see old data
  always_ff @(posedge clk) begin
    if (prog_en) begin
      case (prog_sel)
        PROG_RED: red_mem[prog_addr[7:0]] <= prog_data[COLW-1:0];
        PROG_GRN: grn_mem[prog_addr[7:0]] <= prog_data[COLW-1:0];
        PROG_BLU: blu_mem[prog_addr[7:0]] <= prog_data[COLW-1:0];
        default:  lut_mem[prog_addr]      <= prog_data;
      endcase
    end
  end

  assign flip_act = flip_act_q;
  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign LHBL_dly = hbl_sh_q[VMIX_DLY-1];
  assign LVBL_dly = vbl_sh_q[VMIX_DLY-1];

endmodule

`default_nettype wire
